up_down_range_counter: RTL and testbench

Parametrised up/down counter generalising the library's basic saturating counter with programmable bounds, a per-cycle step size, synchronous load, selectable saturate/wrap behaviour, and terminal-count flags. It serves as the general counting primitive for address generators, timers and modulo sequencers. All outputs are registered or decoded directly from registered state.

---
 rtl/up_down_range_counter.sv | 112 +++++++++++
 tb/tb_up_down_range_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/up_down_range_counter.sv
// Up/down counter with programmable bounds, per-cycle step, synchronous load and terminal-count flags.
// Define UP_DOWN_RANGE_COUNTER_WRAP_EN to honour WrapMode; otherwise the counter always saturates.
module up_down_range_counter #(
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int MIN_VALUE       = 0,
    parameter int MAX_VALUE       = 2**INPUT_BIT_WIDTH - 1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Enable,
    input  logic                       UpDownMode,
    input  logic                       WrapMode,
    input  logic [INPUT_BIT_WIDTH-1:0] Step,
    input  logic                       Load,
    input  logic [INPUT_BIT_WIDTH-1:0] LoadValue,
    output logic [INPUT_BIT_WIDTH-1:0] Output,
    output logic                       AtMin,
    output logic                       AtMax,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int W  = INPUT_BIT_WIDTH;
    localparam int XW = INPUT_BIT_WIDTH + 2;

    // Bound arithmetic is done two bits wider so sums, RANGE and borrows never lose a carry.
    localparam logic [XW-1:0] MIN_X   = XW'(MIN_VALUE);
    localparam logic [XW-1:0] MAX_X   = XW'(MAX_VALUE);
    localparam logic [XW-1:0] RANGE_X = XW'(MAX_VALUE - MIN_VALUE + 1);
    localparam logic [W-1:0]  MIN_C   = W'(MIN_VALUE);
    localparam logic [W-1:0]  MAX_C   = W'(MAX_VALUE);

`ifdef UP_DOWN_RANGE_COUNTER_WRAP_EN
    localparam logic [XW-1:0] ONE_X   = XW'(1);
`else
    logic unused_wrap_mode;
    assign unused_wrap_mode = WrapMode;
`endif

    logic [W-1:0]    count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    logic [XW-1:0]   count_x, step_x, load_x;
    logic [XW-1:0]   step_eff, sum_x, floor_x;
    logic            below_min;
    logic [XW-2:0]   unused_load_diff;

    assign count_x  = XW'(count_q);
    assign step_x   = XW'(Step);
    assign load_x   = XW'(LoadValue);
    // An oversized step behaves as a full-range step.
    assign step_eff = (step_x > RANGE_X) ? RANGE_X : step_x;
    assign sum_x    = count_x + step_eff;
    assign floor_x  = MIN_X + step_eff;
    // Borrow of LoadValue-MIN: avoids a compare that is constant when MIN_VALUE is zero.
    assign {below_min, unused_load_diff} = load_x - MIN_X;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (Load) begin
            if (below_min)           count_d = MIN_C;
            else if (load_x > MAX_X) count_d = MAX_C;
            else                     count_d = LoadValue;
        end else if (Enable) begin
            if (UpDownMode) begin
                if (sum_x > MAX_X) begin
                    overflow_d = 1'b1;
                    count_d    = MAX_C;
`ifdef UP_DOWN_RANGE_COUNTER_WRAP_EN
                    if (WrapMode) count_d = W'(MIN_X + (sum_x - MAX_X - ONE_X));
`endif
                end else begin
                    count_d = W'(sum_x);
                end
            end else begin
                if (count_x < floor_x) begin
                    underflow_d = 1'b1;
                    count_d     = MIN_C;
`ifdef UP_DOWN_RANGE_COUNTER_WRAP_EN
                    if (WrapMode) count_d = W'(MAX_X - (floor_x - count_x - ONE_X));
`endif
                end else begin
                    count_d = W'(count_x - step_eff);
                end
            end
        end
    end

    // NOTE: non-blocking assignments so all three registers update from the same pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q     <= MIN_C;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign Output    = count_q;
    assign AtMin     = (count_q == MIN_C);
    assign AtMax     = (count_q == MAX_C);
    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;

endmodule

// File: tb/tb_up_down_range_counter.sv
// Self-checking bench: two counter instances (0..255 and 10..20) against an integer reference model.
// Directed steps follow the counter's intended use cases, then a randomized phase.
module tb_up_down_range_counter;

`ifdef UP_DOWN_RANGE_COUNTER_WRAP_EN
    localparam bit WRAP_BUILT = 1'b1;
`else
    localparam bit WRAP_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, enable, up, wrap, load;
    logic [7:0] step, load_value;

    logic [7:0] out_a, out_b;
    logic       atmin_a, atmax_a, ovf_a, unf_a;
    logic       atmin_b, atmax_b, ovf_b, unf_b;

    int checks = 0;
    int errors = 0;

    int m_min [2] = '{0, 10};
    int m_max [2] = '{255, 20};
    int m_cnt [2];
    bit m_ovf [2];
    bit m_unf [2];

    always #5 clk = ~clk;

    up_down_range_counter dut_a (
        .Clk(clk), .Reset(reset), .Enable(enable), .UpDownMode(up), .WrapMode(wrap),
        .Step(step), .Load(load), .LoadValue(load_value),
        .Output(out_a), .AtMin(atmin_a), .AtMax(atmax_a), .Overflow(ovf_a), .Underflow(unf_a)
    );

    up_down_range_counter #(.INPUT_BIT_WIDTH(8), .MIN_VALUE(10), .MAX_VALUE(20)) dut_b (
        .Clk(clk), .Reset(reset), .Enable(enable), .UpDownMode(up), .WrapMode(wrap),
        .Step(step), .Load(load), .LoadValue(load_value),
        .Output(out_b), .AtMin(atmin_b), .AtMax(atmax_b), .Overflow(ovf_b), .Underflow(unf_b)
    );

    // Reference model: plain integer arithmetic, modulo-range wrap.
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int rng = m_max[k] - m_min[k] + 1;
            int s   = (int'(step) > rng) ? rng : int'(step);
            int off;
            bit do_wrap = wrap && WRAP_BUILT;
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
            if (reset) begin
                m_cnt[k] = m_min[k];
            end else if (load) begin
                if (int'(load_value) < m_min[k])      m_cnt[k] = m_min[k];
                else if (int'(load_value) > m_max[k]) m_cnt[k] = m_max[k];
                else                                  m_cnt[k] = int'(load_value);
            end else if (enable) begin
                if (up) begin
                    if (m_cnt[k] + s > m_max[k]) begin
                        m_ovf[k] = 1'b1;
                        off = (m_cnt[k] - m_min[k] + s) % rng;
                        m_cnt[k] = do_wrap ? m_min[k] + off : m_max[k];
                    end else begin
                        m_cnt[k] = m_cnt[k] + s;
                    end
                end else begin
                    if (m_cnt[k] - s < m_min[k]) begin
                        m_unf[k] = 1'b1;
                        off = ((m_cnt[k] - m_min[k] - s) % rng + rng) % rng;
                        m_cnt[k] = do_wrap ? m_min[k] + off : m_min[k];
                    end else begin
                        m_cnt[k] = m_cnt[k] - s;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ":a.Output"},    out_a,   m_cnt[0]);
        check({tag, ":a.AtMin"},     atmin_a, m_cnt[0] == m_min[0]);
        check({tag, ":a.AtMax"},     atmax_a, m_cnt[0] == m_max[0]);
        check({tag, ":a.Overflow"},  ovf_a,   m_ovf[0]);
        check({tag, ":a.Underflow"}, unf_a,   m_unf[0]);
        check({tag, ":b.Output"},    out_b,   m_cnt[1]);
        check({tag, ":b.AtMin"},     atmin_b, m_cnt[1] == m_min[1]);
        check({tag, ":b.AtMax"},     atmax_b, m_cnt[1] == m_max[1]);
        check({tag, ":b.Overflow"},  ovf_b,   m_ovf[1]);
        check({tag, ":b.Underflow"}, unf_b,   m_unf[1]);
    endtask

    task automatic load_both(input logic [7:0] value);
        load = 1'b1; load_value = value; enable = 1'b0;
        tick();
        check_all("load");
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up = 1'b1; wrap = 1'b0;
        step = 8'd1; load = 1'b0; load_value = 8'd0;
        tick();
        check_all("reset");
        check("reset_out_a", out_a, 0);
        check("reset_atmin_a", atmin_a, 1);
        check("reset_atmax_a", atmax_a, 0);
        check("reset_out_b", out_b, 10);

        // Count up 5, then down 10 with saturation at the lower bound.
        reset = 1'b0; enable = 1'b1; up = 1'b1; step = 8'd1;
        for (int i = 0; i < 5; i++) begin tick(); check_all("up5"); end
        check("up5_out_a", out_a, 5);
        up = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_all("down10");
            check("down10_unf_a", unf_a, (i >= 6));
        end
        check("down10_out_a", out_a, 0);
        check("down10_atmin_a", atmin_a, 1);

        // Saturating up-count into the upper bound.
        load_both(8'd250);
        enable = 1'b1; up = 1'b1; wrap = 1'b0; step = 8'd4;
        tick(); check_all("sat1"); check("sat1_out_a", out_a, 254); check("sat1_ovf_a", ovf_a, 0);
        tick(); check_all("sat2"); check("sat2_out_a", out_a, 255); check("sat2_ovf_a", ovf_a, 1);
        tick(); check_all("sat3"); check("sat3_out_a", out_a, 255); check("sat3_ovf_a", ovf_a, 1);
        check("sat3_atmax_a", atmax_a, 1);

        // Wrap across both bounds of the 10..20 instance, then an idle edge.
        load_both(8'd19);
        enable = 1'b1; wrap = 1'b1; up = 1'b1; step = 8'd3;
        tick(); check_all("wrap_up");
        up = 1'b0;
        tick(); check_all("wrap_down");
        enable = 1'b0;
        tick(); check_all("idle");

        // Load clamps and overrides Enable.
        enable = 1'b1; up = 1'b1; step = 8'd1; load = 1'b1; load_value = 8'd5;
        tick(); check_all("load_lo"); check("load_lo_out_b", out_b, 10); check("load_lo_ovf_a", ovf_a, 0);
        load_value = 8'd200;
        tick(); check_all("load_hi"); check("load_hi_out_b", out_b, 20); check("load_hi_out_a", out_a, 200);
        load = 1'b0;

        // Reset wins over Load and Enable; Step=0 holds.
        load_both(8'd15);
        enable = 1'b1; step = 8'd1;
        tick(); check_all("midcount");
        reset = 1'b1; load = 1'b1; load_value = 8'd18;
        tick(); check_all("reset_load"); check("reset_load_out_b", out_b, 10);
        reset = 1'b0; load = 1'b0; step = 8'd0;
        for (int i = 0; i < 2; i++) begin tick(); check_all("step0"); end

        // Edge case near top of the 8-bit range, and oversized steps on the narrow instance.
        load_both(8'd254);
        enable = 1'b1; wrap = 1'b1; up = 1'b1; step = 8'd4;
        tick(); check_all("top_wrap");
        load_both(8'd15);
        enable = 1'b1; step = 8'd50;
        tick(); check_all("big_up");
        up = 1'b0; step = 8'd200;
        tick(); check_all("big_down");

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom % 40) == 0;
            load       = ($urandom % 8) == 0;
            enable     = ($urandom % 4) != 0;
            up         = $urandom % 2;
            wrap       = $urandom % 2;
            step       = (($urandom % 4) == 0) ? 8'($urandom % 256) : 8'($urandom % 12);
            load_value = 8'($urandom % 256);
            tick();
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
